// File: rtl/vpu_ctrl.sv
// Command sequencer for the VPU bias/leaky-ReLU datapath: fetches the bias
// vector, holds mode/leak stable per command and generates UB result writes.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for a command, cmd_ready high
// S_BIAS_REQ  | one-cycle UB bias read request
// S_BIAS_WAIT | bias read data on bias_rd_data, captured this cycle
// S_RUN       | counting result rows, one UB write per valid row
// S_DONE      | one-cycle done pulse, then back to idle
module vpu_ctrl #(
   parameter int DATA_W = 16,
   parameter int SIZE   = 8,
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [3:0]             cmd_pathway,
   input  logic [CNT_W-1:0]       cmd_num_rows,
   input  logic [ADDR_W-1:0]      cmd_bias_addr,
   input  logic [ADDR_W-1:0]      cmd_out_addr,
   input  logic [DATA_W-1:0]      cmd_leak,
   output logic                   bias_rd_en,
   output logic [ADDR_W-1:0]      bias_rd_addr,
   input  logic [DATA_W*SIZE-1:0] bias_rd_data,
   output logic [3:0]             vpu_data_pathway,
   output logic [DATA_W*SIZE-1:0] bias_scalar_out,
   output logic [DATA_W-1:0]      lr_leak_factor_out,
   input  logic                   dp_valid_out,
   output logic                   ub_wr_en,
   output logic [ADDR_W-1:0]      ub_wr_addr,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   typedef enum logic [2:0] {
      S_IDLE, S_BIAS_REQ, S_BIAS_WAIT, S_RUN, S_DONE
   } state_t;

   localparam logic [3:0] PW_LEAKY_ONLY = 4'b0100;

   state_t                  state_q, state_d;
   logic [3:0]              pathway_q, pathway_d;
   logic [CNT_W-1:0]        num_rows_q, num_rows_d;
   logic [CNT_W-1:0]        row_cnt_q, row_cnt_d;
   logic [ADDR_W-1:0]       bias_addr_q, bias_addr_d;
   logic [ADDR_W-1:0]       out_addr_q, out_addr_d;
   logic [DATA_W-1:0]       leak_q, leak_d;
   logic [DATA_W*SIZE-1:0]  bias_q, bias_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pathway_q   <= '0;
         num_rows_q  <= '0;
         row_cnt_q   <= '0;
         bias_addr_q <= '0;
         out_addr_q  <= '0;
         leak_q      <= '0;
         bias_q      <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pathway_q   <= pathway_d;
         num_rows_q  <= num_rows_d;
         row_cnt_q   <= row_cnt_d;
         bias_addr_q <= bias_addr_d;
         out_addr_q  <= out_addr_d;
         leak_q      <= leak_d;
         bias_q      <= bias_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pathway_d   = pathway_q;
      num_rows_d  = num_rows_q;
      row_cnt_d   = row_cnt_q;
      bias_addr_d = bias_addr_q;
      out_addr_d  = out_addr_q;
      leak_d      = leak_q;
      bias_d      = bias_q;
      // a row outside RUN is dropped and flagged until reset
      err_d       = err_q | (dp_valid_out && (state_q != S_RUN));

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               pathway_d   = cmd_pathway;
               num_rows_d  = cmd_num_rows;
               bias_addr_d = cmd_bias_addr;
               out_addr_d  = cmd_out_addr;
               leak_d      = cmd_leak;
               row_cnt_d   = '0;
               if (cmd_num_rows == '0)
                  state_d = S_DONE;
               else if (cmd_pathway == PW_LEAKY_ONLY)
                  state_d = S_RUN;
               else
                  state_d = S_BIAS_REQ;
            end
         end
         S_BIAS_REQ:  state_d = S_BIAS_WAIT;
         S_BIAS_WAIT: begin
            bias_d  = bias_rd_data;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (dp_valid_out) begin
               row_cnt_d = row_cnt_q + CNT_W'(1);
               if (row_cnt_q == num_rows_q - CNT_W'(1))
                  state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      done_d = (state_d == S_DONE);
   end

   assign cmd_ready          = (state_q == S_IDLE);
   assign busy               = (state_q != S_IDLE);
   assign bias_rd_en         = (state_q == S_BIAS_REQ);
   assign bias_rd_addr       = bias_addr_q;
   assign ub_wr_en           = (state_q == S_RUN) && dp_valid_out;
   assign ub_wr_addr         = out_addr_q + ADDR_W'(row_cnt_q);
   assign vpu_data_pathway   = pathway_q;
   assign bias_scalar_out    = bias_q;
   assign lr_leak_factor_out = leak_q;
   assign done               = done_q;
   assign err                = err_q;

endmodule

// File: tb/tb_vpu_ctrl.sv
// Directed bench for vpu_ctrl: UB write addresses are checked against a
// queue of expected addresses filled when each command is issued.
module tb_vpu_ctrl;
   localparam int DATA_W = 16;
   localparam int SIZE   = 8;
   localparam int ADDR_W = 12;
   localparam int CNT_W  = 10;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [3:0]             cmd_pathway;
   logic [CNT_W-1:0]       cmd_num_rows;
   logic [ADDR_W-1:0]      cmd_bias_addr;
   logic [ADDR_W-1:0]      cmd_out_addr;
   logic [DATA_W-1:0]      cmd_leak;
   logic                   bias_rd_en;
   logic [ADDR_W-1:0]      bias_rd_addr;
   logic [DATA_W*SIZE-1:0] bias_rd_data;
   logic [3:0]             vpu_data_pathway;
   logic [DATA_W*SIZE-1:0] bias_scalar_out;
   logic [DATA_W-1:0]      lr_leak_factor_out;
   logic                   dp_valid_out;
   logic                   ub_wr_en;
   logic [ADDR_W-1:0]      ub_wr_addr;
   logic                   busy;
   logic                   done;
   logic                   err;

   vpu_ctrl #(.DATA_W(DATA_W), .SIZE(SIZE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pathway(cmd_pathway),
      .cmd_num_rows(cmd_num_rows), .cmd_bias_addr(cmd_bias_addr),
      .cmd_out_addr(cmd_out_addr), .cmd_leak(cmd_leak),
      .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
      .vpu_data_pathway(vpu_data_pathway), .bias_scalar_out(bias_scalar_out),
      .lr_leak_factor_out(lr_leak_factor_out), .dp_valid_out(dp_valid_out),
      .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] BV1 = 128'h0011_0022_0033_0044_0055_0066_0077_0088;
   localparam logic [127:0] BV2 = 128'hA001_B002_C003_D004_E005_F006_1007_2008;
   localparam logic [127:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

   int n_cmp  = 0;
   int n_fail = 0;
   int rd_cnt = 0;
   logic [ADDR_W-1:0] exp_q[$];
   logic [ADDR_W-1:0] exp_addr;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // write monitor: every UB write must match the next queued address
   always @(negedge clk) begin
      if (bias_rd_en) rd_cnt++;
      if (ub_wr_en === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL unexpected_write observed=%0h expected=none", ub_wr_addr);
         end else begin
            exp_addr = exp_q.pop_front();
            assert (ub_wr_addr === exp_addr) else begin
               n_fail++;
               $error("FAIL wr_addr observed=%0h expected=%0h", ub_wr_addr, exp_addr);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] pw, input logic [CNT_W-1:0] rows,
                        input logic [ADDR_W-1:0] baddr, input logic [ADDR_W-1:0] oaddr,
                        input logic [DATA_W-1:0] leak);
      cmd_pathway   = pw;
      cmd_num_rows  = rows;
      cmd_bias_addr = baddr;
      cmd_out_addr  = oaddr;
      cmd_leak      = leak;
      cmd_valid     = 1'b1;
      chk("cmd_ready_at_issue", 128'(cmd_ready), 128'd1);
      for (int i = 0; i < int'(rows); i++) exp_q.push_back(oaddr + ADDR_W'(i));
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic row();
      dp_valid_out = 1'b1;
      step();
      dp_valid_out = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_pathway = '0; cmd_num_rows = '0;
      cmd_bias_addr = '0; cmd_out_addr = '0; cmd_leak = '0;
      bias_rd_data = '0; dp_valid_out = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      chk("rst_cmd_ready", 128'(cmd_ready), 128'd1);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      chk("rst_err", 128'(err), 128'd0);
      chk("rst_pathway", 128'(vpu_data_pathway), 128'd0);
      chk("rst_bias", bias_scalar_out, 128'd0);
      chk("rst_leak", 128'(lr_leak_factor_out), 128'd0);

      // bias + leaky, rows with gaps, stray command during RUN
      rd_cnt = 0;
      issue(4'b1100, 10'd4, 12'h010, 12'h100, 16'h0019);
      chk("bl_rd_en", 128'(bias_rd_en), 128'd1);
      chk("bl_rd_addr", 128'(bias_rd_addr), 128'h010);
      chk("bl_busy", 128'(busy), 128'd1);
      chk("bl_ready_low", 128'(cmd_ready), 128'd0);
      chk("bl_pathway", 128'(vpu_data_pathway), 128'hC);
      chk("bl_leak", 128'(lr_leak_factor_out), 128'h19);
      step();
      chk("bl_rd_en_single", 128'(bias_rd_en), 128'd0);
      bias_rd_data = BV1;
      step();
      bias_rd_data = JUNK;
      chk("bl_bias_loaded", bias_scalar_out, BV1);
      row(); step();
      row();
      cmd_pathway = 4'b0100; cmd_num_rows = 10'd9; cmd_out_addr = 12'h777;
      cmd_leak = 16'h7777; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("bl_pathway_held", 128'(vpu_data_pathway), 128'hC);
      chk("bl_leak_held", 128'(lr_leak_factor_out), 128'h19);
      row(); step();
      chk("bl_no_done_early", 128'(done), 128'd0);
      row();
      chk("bl_done", 128'(done), 128'd1);
      chk("bl_bias_kept", bias_scalar_out, BV1);
      step();
      chk("bl_done_pulse", 128'(done), 128'd0);
      chk("bl_idle_ready", 128'(cmd_ready), 128'd1);
      chk("bl_rd_cnt", 128'(rd_cnt), 128'd1);
      chk("bl_writes_all", 128'(exp_q.size()), 128'd0);

      // leaky only: no bias fetch, RUN one cycle after accept
      rd_cnt = 0;
      issue(4'b0100, 10'd2, 12'h020, 12'h200, 16'h0080);
      chk("lk_busy", 128'(busy), 128'd1);
      chk("lk_pathway", 128'(vpu_data_pathway), 128'h4);
      chk("lk_leak", 128'(lr_leak_factor_out), 128'h80);
      row(); row();
      chk("lk_done", 128'(done), 128'd1);
      step();
      chk("lk_rd_cnt", 128'(rd_cnt), 128'd0);
      chk("lk_bias_unchanged", bias_scalar_out, BV1);
      chk("lk_writes_all", 128'(exp_q.size()), 128'd0);

      // zero rows
      rd_cnt = 0;
      issue(4'b1100, 10'd0, 12'h030, 12'h300, 16'h0001);
      chk("z_done", 128'(done), 128'd1);
      chk("z_ready_low", 128'(cmd_ready), 128'd0);
      step();
      chk("z_done_pulse", 128'(done), 128'd0);
      chk("z_ready", 128'(cmd_ready), 128'd1);
      chk("z_rd_cnt", 128'(rd_cnt), 128'd0);

      // address wrap, bias only, back-to-back rows
      issue(4'b1000, 10'd4, 12'h040, 12'hFFE, 16'h0002);
      step();
      bias_rd_data = BV2;
      step();
      bias_rd_data = JUNK;
      chk("wr_bias_loaded", bias_scalar_out, BV2);
      row(); row(); row(); row();
      chk("wr_done", 128'(done), 128'd1);
      step();
      chk("wr_writes_all", 128'(exp_q.size()), 128'd0);
      chk("wr_err_clear", 128'(err), 128'd0);

      // stray row in IDLE sets sticky err; next command runs normally
      row();
      chk("st_err", 128'(err), 128'd1);
      issue(4'b1111, 10'd1, 12'h050, 12'h040, 16'h0003);
      chk("st_other_fetches", 128'(bias_rd_en), 128'd1);
      step(); step();
      row();
      chk("st_done", 128'(done), 128'd1);
      step();
      chk("st_err_sticky", 128'(err), 128'd1);
      chk("st_writes_all", 128'(exp_q.size()), 128'd0);

      // reset mid-RUN after 2 of 4 rows
      exp_q.push_back(12'h300);
      exp_q.push_back(12'h301);
      cmd_pathway = 4'b0100; cmd_num_rows = 10'd4; cmd_out_addr = 12'h300;
      cmd_leak = 16'h0040; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      row(); row();
      rst = 1'b1;
      #2;
      chk("mr_busy", 128'(busy), 128'd0);
      chk("mr_err", 128'(err), 128'd0);
      chk("mr_pathway", 128'(vpu_data_pathway), 128'd0);
      chk("mr_leak", 128'(lr_leak_factor_out), 128'd0);
      chk("mr_bias", bias_scalar_out, 128'd0);
      step();
      rst = 1'b0;
      step();
      chk("mr_ready", 128'(cmd_ready), 128'd1);
      chk("mr_no_done", 128'(done), 128'd0);
      chk("mr_writes", 128'(exp_q.size()), 128'd0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
